// File: rtl/hamming_display_scan_pkg.sv
// hamming_display_scan_pkg: shared segment constants and digit-scan encoding
package hamming_display_scan_pkg;
  localparam int DIG_COUNT = 4;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_E = 7'h79;
  // Scan position counts up from zero, so the reset value selects the leftmost digit first
  typedef enum logic [1:0] {DIG_D3, DIG_D2, DIG_D1, DIG_D0} dig_t;
  function automatic logic [1:0] dig_num(dig_t d);
    return 2'd3 - d;
  endfunction
endpackage

// File: rtl/hamming_display_scan_if.sv
// hamming_display_scan_if: capture inputs and display drive outputs
interface hamming_display_scan_if;
  logic load;
  logic [3:0] data_in;
  logic [2:0] syndrome;
  logic [6:0] segments;
  logic [3:0] anodes;
  logic err_led;
  modport master(output load, data_in, syndrome, input segments, anodes, err_led);
  modport slave(input load, data_in, syndrome, output segments, anodes, err_led);
endinterface

// File: rtl/hamming_display_scan_hex_to_7seg.sv
// hex_to_7seg: nibble to active-high g..a segment pattern
module hex_to_7seg (
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  localparam logic [6:0] FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  assign seg = FONT[nib];
endmodule

// File: rtl/hamming_display_scan.sv
// hamming_display_scan: captures corrector output and scans it onto a 4-digit 7-segment display
module hamming_display_scan
  import hamming_display_scan_pkg::*;
#(
  parameter int SCAN_DIV = 6750,
  parameter int BLINK_SCANS = 1024,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input logic clk,
  input logic rst,
  hamming_display_scan_if.slave bus
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = BLINK_SCANS > 1 ? $clog2(BLINK_SCANS) : 1;
  localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [3:0] AN_OFF = ACTIVE_LOW ? 4'hF : 4'h0;
  logic [3:0] data_q, err_cnt, nib, an_on;
  logic [2:0] syn_q;
  logic [DW-1:0] div;
  logic [BW-1:0] blink_cnt;
  logic blink, tick, blink_wrap;
  dig_t dig;
  logic [6:0] hex_seg, seg_on;
  assign tick = div == DW'(SCAN_DIV - 1);
  assign blink_wrap = blink_cnt == BW'(BLINK_SCANS - 1);
  assign nib = dig == DIG_D0 ? data_q : dig == DIG_D1 ? {1'b0, syn_q} : err_cnt;
  hex_to_7seg u_font (.nib(nib), .seg(hex_seg));
  assign seg_on = (dig == DIG_D0 || dig == DIG_D3) ? hex_seg
                : dig == DIG_D2 ? (syn_q != 3'd0 ? SEG_E : SEG_BLANK)
                : syn_q == 3'd0 ? SEG_DASH
                : blink ? SEG_BLANK : hex_seg;
  // Slot zero of every digit is dead time so the previous digit's segments never ghost
  assign an_on = div == '0 ? 4'b0000 : 4'b0001 << dig_num(dig);
  // Scan/blink counters, capture registers and saturating error count
  always_ff @(posedge clk) begin
    if (rst) begin
      div <= '0;
      dig <= DIG_D3;
      blink_cnt <= '0;
      blink <= 1'b0;
      data_q <= '0;
      syn_q <= '0;
      err_cnt <= '0;
    end else begin
      div <= tick ? '0 : div + 1'b1;
      if (tick) begin
        dig <= dig_t'(dig + 2'd1);
        blink_cnt <= blink_wrap ? '0 : blink_cnt + 1'b1;
        blink <= blink ^ blink_wrap;
      end
      if (bus.load) begin
        data_q <= bus.data_in;
        syn_q <= bus.syndrome;
        if (bus.syndrome != 3'd0 && err_cnt != 4'hF) err_cnt <= err_cnt + 1'b1;
      end
    end
  end
  // Registered display drive with polarity applied
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.segments <= SEG_OFF;
      bus.anodes <= AN_OFF;
      bus.err_led <= 1'b0;
    end else begin
      bus.segments <= ACTIVE_LOW ? ~seg_on : seg_on;
      bus.anodes <= ACTIVE_LOW ? ~an_on : an_on;
      bus.err_led <= syn_q != 3'd0;
    end
  end
endmodule
